alu_reg_file: RTL and testbench

//  Datapath core of the multicycle MIPS CPU: a 32x32 register file (2 async read ports, 1 byte-enabled

---
 rtl/alu_reg_file_pkg.sv | 20 ++
 rtl/alu_reg_file_alu.sv | 74 +++++++
 rtl/alu_reg_file.sv | 73 +++++++
 tb/tb_alu_reg_file.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_reg_file_pkg.sv
// Shared definitions for the MIPS datapath core: datapath/address widths
// and the 3-bit ALU opcode encoding used by the control unit.
package alu_reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_LUI  = 3'b011,
        ALU_SLTU = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_reg_file_alu.sv
// Combinational 32-bit ALU.
// Ports:
//   a_i, b_i      operands
//   op_i          operation select (alu_op_e encoding)
//   result_o      result
//   zero_o        result == 0
//   overflow_o    signed overflow, ADD/SUB only
//   carryout_o    ADD carry / SUB borrow, else 0
// One 33-bit adder serves ADD, SUB, SLT and SLTU; the compares reuse the
// subtract path.
module alu_reg_file_alu
    import alu_reg_file_pkg::*;
#(
    parameter int DATA_W = alu_reg_file_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              carryout_o
);

    alu_op_e           op;
    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              ovf_add;
    logic              ovf_sub;
    logic              borrow;
    logic              slt;

    assign op     = alu_op_e'(op_i);
    assign is_sub = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    assign b_eff  = is_sub ? ~b_i : b_i;
    // A - B computed as A + ~B + 1
    assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    assign ovf_add = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    assign ovf_sub = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    // Subtract carry-out is the inverted borrow
    assign borrow  = ~sum[DATA_W];
    // Sign of the true difference: the truncated sign flips when A-B overflows
    assign slt     = sum[DATA_W-1] ^ ovf_sub;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        carryout_o = 1'b0;
        case (op)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD: begin
                result_o   = sum[DATA_W-1:0];
                overflow_o = ovf_add;
                carryout_o = sum[DATA_W];
            end
            ALU_LUI:  result_o = b_i << 16;
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, borrow};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SUB: begin
                result_o   = sum[DATA_W-1:0];
                overflow_o = ovf_sub;
                carryout_o = borrow;
            end
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, slt};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_reg_file.sv
// Datapath core of the multicycle MIPS CPU: 32x32 register file with two
// combinational read ports and one byte-enabled synchronous write port
// ($0 reads as zero, writes to it are dropped), plus an independent ALU.
// Ports:
//   clk, resetn               clock, async active-low reset (clears all regs)
//   raddr1/raddr2 -> rdata1/2 combinational reads
//   waddr, wen[3:0], wdata    byte-enabled write on rising clk
//   alu_a, alu_b, alu_op      ALU operands / op select
//   alu_result, alu_zero, alu_overflow, alu_carryout   ALU outputs
module alu_reg_file
    import alu_reg_file_pkg::*;
#(
    parameter int DATA_W = alu_reg_file_pkg::DATA_W,
    parameter int ADDR_W = alu_reg_file_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wen,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   alu_a,
    input  logic [DATA_W-1:0]   alu_b,
    input  logic [2:0]          alu_op,
    output logic [DATA_W-1:0]   alu_result,
    output logic                alu_zero,
    output logic                alu_overflow,
    output logic                alu_carryout
);

    localparam int NREG = 1 << ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] wword_d;
    logic              wr_en;

    // Merge enabled bytes of wdata into the current register contents
    always_comb begin
        wword_d = regs_q[waddr];
        for (int i = 0; i < NBYTE; i++) begin
            if (wen[i]) wword_d[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    assign wr_en = (waddr != '0) && (wen != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[waddr] <= wword_d;
        end
    end

    // No write bypass: a same-cycle write is visible only after the edge
    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

    alu_reg_file_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i        (alu_a),
        .b_i        (alu_b),
        .op_i       (alu_op),
        .result_o   (alu_result),
        .zero_o     (alu_zero),
        .overflow_o (alu_overflow),
        .carryout_o (alu_carryout)
    );

endmodule

// File: tb/tb_alu_reg_file.sv
module tb_alu_reg_file;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [31:0] rdata1, rdata2;
    logic [3:0]  wen;
    logic [31:0] wdata, alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow, alu_carryout;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [32];

    alu_reg_file dut (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .waddr(waddr), .wen(wen), .wdata(wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carryout(alu_carryout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural register-file write: byte-merge into the model
    task automatic do_write(input logic [4:0] a, input logic [3:0] e, input logic [31:0] d);
        @(negedge clk);
        waddr = a; wen = e; wdata = d;
        @(posedge clk);
        #1;
        wen = 4'b0000;
        if (a != 0)
            for (int i = 0; i < 4; i++)
                if (e[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        raddr1 = a1; raddr2 = a2;
        #1;
        chk({tag, "_rd1"}, rdata1, mdl[a1]);
        chk({tag, "_rd2"}, rdata2, mdl[a2]);
    endtask

    // Reference ALU from plain wide arithmetic
    function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output logic o, output logic c);
        longint sa, sb, s;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; o = 0; c = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                u = {32'b0, a} + {32'b0, b};
                r = u[31:0]; c = u[32];
                s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd3: r = {b[15:0], 16'h0000};
            3'd4: r = (a < b) ? 32'd1 : 32'd0;
            3'd5: r = a ^ b;
            3'd6: begin
                r = a - b; c = (a < b);
                s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        z = (r == 0);
    endfunction

    task automatic alu_exp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ez, input logic eo, input logic ec);
        alu_op = op; alu_a = a; alu_b = b;
        #1;
        chk({tag, "_res"}, alu_result, er);
        chk({tag, "_zero"}, {31'b0, alu_zero}, {31'b0, ez});
        chk({tag, "_ovf"}, {31'b0, alu_overflow}, {31'b0, eo});
        chk({tag, "_cy"}, {31'b0, alu_carryout}, {31'b0, ec});
    endtask

    task automatic alu_rand(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic z, o, c;
        alu_ref(op, a, b, r, z, o, c);
        alu_exp($sformatf("rnd_op%0d", op), op, a, b, r, z, o, c);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        resetn = 1'b0; raddr1 = 0; raddr2 = 0; waddr = 0; wen = 0; wdata = 0;
        alu_a = 0; alu_b = 0; alu_op = 0;
        repeat (2) @(negedge clk);
        rd_chk("reset_r5_r31", 5'd5, 5'd31);
        resetn = 1'b1;

        // Async reset with no clock edge
        do_write(5'd5, 4'b1111, 32'hDEADBEEF);
        rd_chk("r5_written", 5'd5, 5'd0);
        @(negedge clk);
        #1 resetn = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        raddr1 = 5'd5;
        #1 chk("async_reset_r5", rdata1, 32'h0);
        #1 resetn = 1'b1;

        // Byte enables
        do_write(5'd3, 4'b1111, 32'h11223344);
        do_write(5'd3, 4'b0101, 32'hAABBCCDD);
        raddr1 = 5'd3; #1 chk("byte_wen0101", rdata1, 32'h11BB33DD);
        do_write(5'd3, 4'b0000, 32'h99999999);
        raddr1 = 5'd3; #1 chk("byte_wen0000", rdata1, 32'h11BB33DD);

        // $0 stays zero
        do_write(5'd0, 4'b1111, 32'hFFFFFFFF);
        raddr1 = 5'd0; #1 chk("r0_ignored", rdata1, 32'h0);

        // Same-cycle read/write: old value before edge
        do_write(5'd7, 4'b1111, 32'h01234567);
        @(negedge clk);
        raddr1 = 5'd7; waddr = 5'd7; wen = 4'b1111; wdata = 32'h89ABCDEF;
        #1 chk("r7_pre_edge", rdata1, 32'h01234567);
        @(posedge clk);
        #1 wen = 4'b0000;
        mdl[7] = 32'h89ABCDEF;
        chk("r7_post_edge", rdata1, 32'h89ABCDEF);

        // Directed ALU vectors
        alu_exp("add_ovf",   3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0);
        alu_exp("add_wrap",  3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1);
        alu_exp("sub_zero",  3'b110, 32'd5, 32'd5, 32'h0, 1, 0, 0);
        alu_exp("sub_ovf",   3'b110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0);
        alu_exp("sub_brw",   3'b110, 32'h1, 32'h2, 32'hFFFFFFFF, 0, 0, 1);
        alu_exp("slt_neg",   3'b111, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0);
        alu_exp("sltu_big",  3'b100, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0);
        alu_exp("slt_ovf",   3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        alu_exp("slt_ovf2",  3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1, 0, 0);
        alu_exp("and",       3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0);
        alu_exp("or",        3'b001, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 0);
        alu_exp("xor",       3'b101, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0, 0);
        alu_exp("lui",       3'b011, 32'hFFFFFFFF, 32'h1234, 32'h12340000, 0, 0, 0);

        // Random register traffic against the array model
        for (int n = 0; n < 150; n++) begin
            do_write(5'($urandom_range(0, 31)), 4'($urandom), $urandom);
            rd_chk("rnd_rf", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 32; i++) rd_chk("sweep_rf", 5'(i), 5'(31 - i));

        // Random ALU vectors with boundary-biased operands
        for (int n = 0; n < 300; n++)
            alu_rand(3'($urandom_range(0, 7)), pick(), pick());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
